imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It accepts one instruction word per cycle with its PC under a valid/ready handshake. It decodes the immediate format and sign-extends the immediate to XLEN, covering I/S/B/U/J formats plus CSR zimm. Results are held in a 2-entry skid buffer, so back-pressure from execute never forms a combinational path to fetch.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- PC_W, 32: width of the PC tag carried alongside the instruction.

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all buffered entries and the same-cycle input.
- in_valid  in  1  inst/pc valid.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  raw instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  imm_fmt_e format code.
- out_illegal  out  1  unrecognised or non-32-bit encoding.
- out_inst  out  32  instruction passed through.
- out_pc  out  PC_W  PC passed through.

## Operation
- Decode is combinational on in_inst and is written into the buffer on push (in_valid && in_ready && !flush).
- Format by opcode inst[6:0]:
  - 0000011, 0010011, 1100111 → FMT_I: sext(inst[31:20]).
  - 0011011 → FMT_I when XLEN=64; otherwise illegal.
  - 0100011 → FMT_S: sext({inst[31:25],inst[11:7]}).
  - 1100011 → FMT_B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111 → FMT_U: sext({inst[31:12],12'b0}). On XLEN=64, bit 31 replicates upward.
  - 1101111 → FMT_J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1110011 with funct3[2]=1 → FMT_Z: zero-extended inst[19:15].
  - 1110011 with funct3[2]=0 → FMT_I.
  - 0110011, 0001111, and 0111011 (XLEN=64 only) → FMT_NONE, imm 0, not illegal.
  - Any other opcode, or inst[1:0]≠2'b11 → FMT_NONE, imm 0, out_illegal=1.
- Buffer: 2-entry FIFO with occupancy count 0..2. Head is presented on out_*.
  - Pop on out_valid && out_ready.
  - in_ready = !rst && (count<2). It is registered-state-derived only and never depends on out_ready.
  - Push and pop in the same cycle at count=1 → count stays 1, order preserved.
  - At count=2, no push is possible; a pop drops count to 1.
  - At count=0, no pop.
- out_valid = (count≠0).
- flush: count←0 next cycle. Same-cycle input is not captured, and a same-cycle pop has no further effect. flush has priority over push and pop.
- rst: count←0.
  - During and after reset, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_inst=0, out_pc=0, out_valid=0, in_ready=0 while rst is high.
  - Reset mid-operation discards all entries.

## Timing
- Latency: an input pushed at edge N is visible on out_* after edge N (one cycle).
- Throughput: 1 instr/cycle while out_ready is held high.
- out_* hold stable while out_valid && !out_ready.
- Once in_ready falls, it rises again no later than one cycle after the first pop.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Structure
- Package imm_gen_pkg contains:
  - imm_fmt_e (3-bit: FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z).
  - Opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_OP, OPC_OP_32, OPC_MISC_MEM).
  - Buffer entry struct.
- Sub-module imm_decode (combinational, parameter XLEN): inst → {imm, fmt, illegal}. It is instantiated once on the input side.
- The top level holds two entry registers, a head pointer and the count.

## Test plan
- XLEN=32, reset then push 0xFFF00093 (addi -1) → one cycle later out_valid=1, out_imm=0xFFFFFFFF, fmt=FMT_I.
- Push 0xFE112E23 (sw -4) then 0xFE000CE3 (beq -8) back-to-back → 0xFFFFFFFC/FMT_S, then 0xFFFFFFF8/FMT_B on consecutive cycles.
- Push 0x12345017 → 0x12345000/FMT_U. With XLEN=64, push 0x800000B7 → 0xFFFFFFFF80000000. With XLEN=32, push 0x0000001B → illegal=1, imm=0.
- out_ready=0, offer 3 instructions → first two accepted, in_ready=0 with the third held. Raise out_ready → all three emerge in order, none lost or duplicated.
- Count=2, assert flush with in_valid=1 → next cycle out_valid=0, and the flushed input never appears.
- Push 0x0000007F and 0x00000001 → both FMT_NONE, imm 0, illegal=1. Push 0x00000033 → FMT_NONE, illegal=0.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format codes, opcodes, buffer metadata.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    // Width-independent part of a buffer entry; imm and pc are sized by the stage parameters.
    typedef struct packed {
        imm_fmt_e    fmt;
        logic        illegal;
        logic [31:0] inst;
    } imm_meta_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out handshake bundle; slave is the stage, master is the environment.
interface imm_gen_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    import imm_gen_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    imm_fmt_e        out_fmt;
    logic            out_illegal;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );

endinterface

// File: rtl/imm_decode.sv
// Immediate format decode and extension to XLEN.
// Latency: combinational.
// Backpressure: none, pure function of inst.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] sel32;

    // Every format is built as a 32-bit signed value and widened once at the end.
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        sel32   = '0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                fmt   = FMT_I;
                sel32 = imm_i;
            end
            OPC_OP_IMM_32: begin
                if (RV64) begin
                    fmt   = FMT_I;
                    sel32 = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                sel32 = imm_s;
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                sel32 = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                sel32 = imm_u;
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                sel32 = imm_j;
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    fmt = FMT_Z;
                end else begin
                    fmt   = FMT_I;
                    sel32 = imm_i;
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                fmt = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal = !RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = (fmt == FMT_Z) ? XLEN'(inst[19:15]) : XLEN'($signed(sel32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage feeding a 2-entry skid buffer.
// Latency: one cycle from accepted input to out_*.
// Backpressure: in_ready comes only from buffer occupancy, never from out_ready.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    imm_gen_stage_if.slave   bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
        imm_meta_t       meta;
    } entry_t;

    entry_t          ent_q [2];
    logic            head_q;
    logic [1:0]      count_q;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          new_ent;
    entry_t          head_ent;
    logic            rdy;
    logic            vld;
    logic            push;
    logic            pop;
    logic            wr_idx;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (bus.in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign rdy    = !rst && (count_q != 2'd2);
    assign vld    = !rst && (count_q != 2'd0);
    assign push   = bus.in_valid && rdy && !bus.flush;
    assign pop    = vld && bus.out_ready && !bus.flush;
    assign wr_idx = head_q ^ count_q[0];

    always_comb begin
        new_ent.imm          = dec_imm;
        new_ent.pc           = bus.in_pc;
        new_ent.meta.fmt     = dec_fmt;
        new_ent.meta.illegal = dec_illegal;
        new_ent.meta.inst    = bus.in_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else if (bus.flush) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
        end else begin
            if (push) begin
                ent_q[wr_idx] <= new_ent;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Invalid head reads as all-zero so stale entries never leak onto out_*.
    assign head_ent        = vld ? ent_q[head_q] : '0;

    assign bus.in_ready    = rdy;
    assign bus.out_valid   = vld;
    assign bus.out_imm     = head_ent.imm;
    assign bus.out_fmt     = head_ent.meta.fmt;
    assign bus.out_illegal = head_ent.meta.illegal;
    assign bus.out_inst    = head_ent.meta.inst;
    assign bus.out_pc      = head_ent.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage at XLEN=32 plus a small XLEN=64 instance for RV64-only encodings.
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .PC_W(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64), .PC_W(32)) b64 ();

    imm_gen_stage #(.XLEN(32), .PC_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    imm_gen_stage #(.XLEN(64), .PC_W(32)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] imm,
                           input imm_fmt_e f, input logic ill);
        chk({tag, ".valid"}, 64'(b32.out_valid), 64'(v));
        chk({tag, ".imm"}, 64'(b32.out_imm), 64'(imm));
        chk({tag, ".fmt"}, 64'(b32.out_fmt), 64'(f));
        chk({tag, ".illegal"}, 64'(b32.out_illegal), 64'(ill));
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        b32.in_valid = 1'b1;
        b32.in_inst  = inst;
        b32.in_pc    = pc;
    endtask

    initial begin
        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
        b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b0;

        // Reset, with an input offered that must be ignored
        offer(32'h0010_0093, 32'h50);
        tick();
        tick();
        chk("rst.in_ready", 64'(b32.in_ready), 64'd0);
        chk("rst.out_inst", 64'(b32.out_inst), 64'd0);
        chk("rst.out_pc", 64'(b32.out_pc), 64'd0);
        chk_out("rst", 1'b0, 32'h0, FMT_NONE, 1'b0);
        rst = 1'b0;
        b32.in_valid = 1'b0;
        #1;
        chk("idle.in_ready", 64'(b32.in_ready), 64'd1);
        tick();
        chk("idle.out_valid", 64'(b32.out_valid), 64'd0);

        // Streaming at full rate with out_ready high
        b32.out_ready = 1'b1;
        offer(32'hFFF0_0093, 32'h100);
        tick();
        chk_out("addi", 1'b1, 32'hFFFF_FFFF, FMT_I, 1'b0);
        chk("addi.pc", 64'(b32.out_pc), 64'h100);
        chk("addi.inst", 64'(b32.out_inst), 64'hFFF0_0093);
        offer(32'hFE11_2E23, 32'h104);
        tick();
        chk_out("sw", 1'b1, 32'hFFFF_FFFC, FMT_S, 1'b0);
        offer(32'hFE00_0CE3, 32'h108);
        tick();
        chk_out("beq", 1'b1, 32'hFFFF_FFF8, FMT_B, 1'b0);
        chk("beq.pc", 64'(b32.out_pc), 64'h108);
        offer(32'h1234_5017, 32'h10C);
        tick();
        chk_out("auipc", 1'b1, 32'h1234_5000, FMT_U, 1'b0);
        offer(32'hFFDF_F06F, 32'h110);
        tick();
        chk_out("jal", 1'b1, 32'hFFFF_FFFC, FMT_J, 1'b0);
        offer(32'h000F_D073, 32'h114);
        tick();
        chk_out("csrrwi", 1'b1, 32'h0000_001F, FMT_Z, 1'b0);
        offer(32'h3401_1073, 32'h118);
        tick();
        chk_out("csrrw", 1'b1, 32'h0000_0340, FMT_I, 1'b0);
        offer(32'h0000_001B, 32'h11C);
        tick();
        chk_out("addiw32", 1'b1, 32'h0, FMT_NONE, 1'b1);
        offer(32'h0000_007F, 32'h120);
        tick();
        chk_out("badopc", 1'b1, 32'h0, FMT_NONE, 1'b1);
        offer(32'h0000_0001, 32'h124);
        tick();
        chk_out("rvc", 1'b1, 32'h0, FMT_NONE, 1'b1);
        offer(32'h0000_0033, 32'h128);
        tick();
        chk_out("op", 1'b1, 32'h0, FMT_NONE, 1'b0);
        b32.in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 64'(b32.out_valid), 64'd0);

        // Backpressure: fill both entries, third input held off
        b32.out_ready = 1'b0;
        offer(32'h0010_0093, 32'h200);
        tick();
        chk("bp1.in_ready", 64'(b32.in_ready), 64'd1);
        chk_out("bp1", 1'b1, 32'h1, FMT_I, 1'b0);
        offer(32'h0020_0093, 32'h204);
        tick();
        chk("bp2.in_ready", 64'(b32.in_ready), 64'd0);
        chk_out("bp2", 1'b1, 32'h1, FMT_I, 1'b0);
        offer(32'h0030_0093, 32'h208);
        tick();
        chk("bp3.in_ready", 64'(b32.in_ready), 64'd0);
        chk_out("bp3.hold", 1'b1, 32'h1, FMT_I, 1'b0);
        chk("bp3.pc", 64'(b32.out_pc), 64'h200);
        b32.out_ready = 1'b1;
        tick();
        chk_out("bp.second", 1'b1, 32'h2, FMT_I, 1'b0);
        chk("bp.reready", 64'(b32.in_ready), 64'd1);
        tick();
        chk_out("bp.third", 1'b1, 32'h3, FMT_I, 1'b0);
        chk("bp.third.pc", 64'(b32.out_pc), 64'h208);
        b32.in_valid = 1'b0;
        tick();
        chk("bp.empty", 64'(b32.out_valid), 64'd0);

        // Flush at count=2 with an input offered
        b32.out_ready = 1'b0;
        offer(32'h0040_0093, 32'h300);
        tick();
        offer(32'h0050_0093, 32'h304);
        tick();
        chk("fl2.full", 64'(b32.in_ready), 64'd0);
        offer(32'h0060_0093, 32'h308);
        b32.flush = 1'b1;
        tick();
        chk("fl2.out_valid", 64'(b32.out_valid), 64'd0);
        chk("fl2.in_ready", 64'(b32.in_ready), 64'd1);
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        tick();
        chk("fl2.after", 64'(b32.out_valid), 64'd0);

        // Flush at count=1 with pop and push requested in the same cycle
        b32.out_ready = 1'b1;
        offer(32'h0070_0093, 32'h400);
        tick();
        offer(32'h0080_0093, 32'h404);
        b32.flush = 1'b1;
        tick();
        chk("fl1.out_valid", 64'(b32.out_valid), 64'd0);
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        tick();
        chk("fl1.after", 64'(b32.out_valid), 64'd0);

        // Reset mid-operation discards buffered entries
        b32.out_ready = 1'b0;
        offer(32'h0090_0093, 32'h500);
        tick();
        chk("mr.loaded", 64'(b32.out_valid), 64'd1);
        b32.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr.valid_in_rst", 64'(b32.out_valid), 64'd0);
        chk("mr.ready_in_rst", 64'(b32.in_ready), 64'd0);
        chk("mr.imm_in_rst", 64'(b32.out_imm), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr.after", 64'(b32.out_valid), 64'd0);
        chk("mr.ready", 64'(b32.in_ready), 64'd1);

        // XLEN=64 instance
        b64.out_ready = 1'b1;
        b64.in_valid  = 1'b1;
        b64.in_inst   = 32'h8000_00B7;
        b64.in_pc     = 32'h600;
        tick();
        chk("rv64.lui.imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("rv64.lui.fmt", 64'(b64.out_fmt), 64'(FMT_U));
        b64.in_inst = 32'hFFF0_0093;
        tick();
        chk("rv64.addi.imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        b64.in_inst = 32'h0000_001B;
        tick();
        chk("rv64.addiw.fmt", 64'(b64.out_fmt), 64'(FMT_I));
        chk("rv64.addiw.ill", 64'(b64.out_illegal), 64'd0);
        b64.in_inst = 32'h0000_003B;
        tick();
        chk("rv64.op32.fmt", 64'(b64.out_fmt), 64'(FMT_NONE));
        chk("rv64.op32.ill", 64'(b64.out_illegal), 64'd0);
        b64.in_valid = 1'b0;
        tick();
        chk("rv64.empty", 64'(b64.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
